hazard_control: RTL and testbench

Hazard and stall controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).

- **Role:**
  - The forwarding unit consumes results that producers have already computed.
  - This block handles the producer side: the cases where a result does not exist yet, or where the pipeline must be redirected.
- **What it does:**
  - Detects load-use hazards and inserts a one-cycle bubble.
  - Freezes the whole pipeline while data memory is not ready, with a timeout.
  - Flushes wrong-path instructions on a taken JAL, JAL_R or branch.
  - Keeps saturating stall and flush counters for performance monitoring.
- **Placement:** between the ID/EX/MEM pipeline registers and the PC/IF-ID/ID-EX write-enable and flush controls.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/hazard_control_if.sv | 42 ++++
 rtl/sat_counter.sv | 34 +++
 rtl/hazard_control.sv | 136 +++++++++++++
 tb/tb_hazard_control.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: jump types, hazard FSM states, forwarding selects.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pipe_pkg;

  // Jump type carried by the EX-stage instruction
  localparam logic [1:0] NO_JUMP = 2'b00;
  localparam logic [1:0] JAL     = 2'b01;
  localparam logic [1:0] JAL_R   = 2'b10;

  // Hazard controller FSM states
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } hz_state_e;

  // Operand select encodings shared with the forwarding unit
  typedef enum logic [2:0] {
    FWD_RF       = 3'd0,  // register file read
    FWD_EX_ALU   = 3'd1,  // ALU result in EX/MEM
    FWD_MEM_ALU  = 3'd2,  // ALU result in MEM/WB
    FWD_MEM_LOAD = 3'd3,  // load data in MEM/WB
    FWD_WB       = 3'd4   // value being written back
  } fwd_sel_e;

  // True when the EX instruction redirects the fetch stream
  function automatic logic is_redirect(input logic [1:0] jump_t, input logic br_taken);
    return (jump_t != NO_JUMP) | br_taken;
  endfunction

endpackage

// File: rtl/hazard_control_if.sv
// Groups the ID/EX/MEM hazard inputs and the pipeline enable/flush controls.
// Latency: n/a (wires only).
// Backpressure: n/a; memory wait is carried in as mem_req/mem_ready.
// Ports: master = pipeline side (drives stage info, receives controls);
//        slave  = hazard controller (reads stage info, drives controls).
interface hazard_control_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] ex_rd;
  logic       ex_reg_we;
  logic       ex_mem_read;
  logic [1:0] ex_jump_t;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_we;
  logic       if_id_we;
  logic       id_ex_we;
  logic       ex_mem_we;
  logic       mem_wb_we;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       pc_sel_target;
  logic       mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_reg_we,
           ex_mem_read, ex_jump_t, ex_branch_taken, mem_req, mem_ready,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, pc_sel_target, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_reg_we,
           ex_mem_read, ex_jump_t, ex_branch_taken, mem_req, mem_ready,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, pc_sel_target, mem_timeout
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Latency: q updates on the rising edge after inc.
// Backpressure: none; inc is sampled every cycle.
// Ports: clk, rst (async active-low), inc (count enable), q (count).
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_control.sv
// Load-use bubble, memory freeze with timeout, and jump/branch flush control.
// Latency: enables/flushes combinational from inputs; state/counters on the rising edge.
// Backpressure: a pending data-memory access (mem_req & ~mem_ready) freezes every stage.
// Ports: clk, rst (async active-low), hz (slave modport: stage info in, controls out),
//        stall_cnt / flush_cnt (saturating performance counters).
module hazard_control
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_control_if.slave  hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

  hz_state_e       state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            redir_pend_q, redir_pend_d;
  logic            mem_timeout_q, mem_timeout_d;

  logic redirect;
  logic take_redir;
  logic lu_hit;
  logic mem_wait;

  assign redirect   = is_redirect(hz.ex_jump_t, hz.ex_branch_taken);
  assign take_redir = redirect | redir_pend_q;
  assign mem_wait   = hz.mem_req & ~hz.mem_ready;
  assign lu_hit     = hz.ex_mem_read & hz.ex_reg_we & (hz.ex_rd != 5'd0) &
                      ((hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd)) |
                       (hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd)));

  // Stage controls, highest priority first: freeze, redirect, load-use bubble.
  // A redirect beats a load-use hit since the ID instruction is wrong-path anyway.
  always_comb begin
    hz.pc_we         = 1'b1;
    hz.if_id_we      = 1'b1;
    hz.id_ex_we      = 1'b1;
    hz.ex_mem_we     = 1'b1;
    hz.mem_wb_we     = 1'b1;
    hz.if_id_flush   = 1'b0;
    hz.id_ex_flush   = 1'b0;
    hz.pc_sel_target = 1'b0;
    if (mem_wait) begin
      hz.pc_we     = 1'b0;
      hz.if_id_we  = 1'b0;
      hz.id_ex_we  = 1'b0;
      hz.ex_mem_we = 1'b0;
      hz.mem_wb_we = 1'b0;
    end else if (take_redir) begin
      hz.pc_sel_target = 1'b1;
      hz.if_id_flush   = 1'b1;
      hz.id_ex_flush   = 1'b1;
    end else if (lu_hit) begin
      hz.pc_we       = 1'b0;
      hz.if_id_we    = 1'b0;
      hz.id_ex_flush = 1'b1;
    end
  end

  // Next state. wait_cnt counts every frozen cycle (including the one that
  // enters MEM_WAIT) and parks at TIMEOUT so it cannot wrap on a long stall.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    redir_pend_d  = 1'b0;
    mem_timeout_d = mem_timeout_q;

    if (mem_wait) begin
      wait_cnt_d   = (wait_cnt_q == WC_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
      // Remember a redirect seen while frozen; it is replayed on the first
      // unfrozen cycle and dropped on that same edge.
      redir_pend_d = redir_pend_q | redirect;
    end

    case (state_q)
      RUN, LU_BUBBLE: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
        end else if (lu_hit && !take_redir) begin
          state_d = LU_BUBBLE;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
          if (wait_cnt_q == WC_MAX) begin
            mem_timeout_d = 1'b1;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      redir_pend_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      redir_pend_q  <= redir_pend_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign hz.mem_timeout = mem_timeout_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~hz.pc_we),
    .q   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hz.if_id_flush),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench for hazard_control (TIMEOUT=4, CNT_W=3).
// Latency: expected controls per cycle are queued at drive time, checked at the next negedge.
// Backpressure: n/a; stimulus is a fixed cycle sequence.
module tb_hazard_control;
  import pipe_pkg::*;

  typedef struct packed {
    logic [4:0] we;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0] fl;   // {if_id_flush, id_ex_flush}
    logic       sel;
    logic       to;
    logic [2:0] sc;
    logic [2:0] fc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] stall_cnt;
  logic [2:0] flush_cnt;

  hazard_control_if hz();

  hazard_control #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .hz        (hz),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   total;
  int   bad;
  int   exp_stall;
  int   exp_flush;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic idle_inputs();
    hz.id_rs1          = 5'd0;
    hz.id_rs2          = 5'd0;
    hz.id_rs1_used     = 1'b0;
    hz.id_rs2_used     = 1'b0;
    hz.ex_rd           = 5'd0;
    hz.ex_reg_we       = 1'b0;
    hz.ex_mem_read     = 1'b0;
    hz.ex_jump_t       = NO_JUMP;
    hz.ex_branch_taken = 1'b0;
    hz.mem_req         = 1'b0;
    hz.mem_ready       = 1'b0;
  endtask

  task automatic load_in_ex(input logic [4:0] rd);
    hz.ex_rd       = rd;
    hz.ex_reg_we   = 1'b1;
    hz.ex_mem_read = 1'b1;
  endtask

  // Queue this cycle's expected outputs, account for the counters, advance a cycle.
  task automatic step(input logic [4:0] we, input logic [1:0] fl, input logic sel, input logic to);
    exp_t e;
    e.we  = we;
    e.fl  = fl;
    e.sel = sel;
    e.to  = to;
    e.sc  = exp_stall[2:0];
    e.fc  = exp_flush[2:0];
    sb.push_back(e);
    if (!we[4] && exp_stall < 7) exp_stall++;
    if (fl[1] && exp_flush < 7) exp_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check_eq("we", 32'({hz.pc_we, hz.if_id_we, hz.id_ex_we, hz.ex_mem_we, hz.mem_wb_we}), 32'(mon_e.we));
      check_eq("flush", 32'({hz.if_id_flush, hz.id_ex_flush}), 32'(mon_e.fl));
      check_eq("pc_sel", 32'(hz.pc_sel_target), 32'(mon_e.sel));
      check_eq("timeout", 32'(hz.mem_timeout), 32'(mon_e.to));
      check_eq("stall_cnt", 32'(stall_cnt), 32'(mon_e.sc));
      check_eq("flush_cnt", 32'(flush_cnt), 32'(mon_e.fc));
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    exp_stall = 0;
    exp_flush = 0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset values with idle inputs
    #12;
    check_eq("rst_we", 32'({hz.pc_we, hz.if_id_we, hz.id_ex_we, hz.ex_mem_we, hz.mem_wb_we}), 32'h1f);
    check_eq("rst_flush", 32'({hz.if_id_flush, hz.id_ex_flush, hz.pc_sel_target}), 32'h0);
    check_eq("rst_timeout", 32'(hz.mem_timeout), 32'h0);
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    check_eq("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    check_eq("rst_state", 32'(dut.state_q), 32'(RUN));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load-use via rs2, then bubble in EX
    load_in_ex(5'd5);
    hz.id_rs1 = 5'd3; hz.id_rs1_used = 1'b1;
    hz.id_rs2 = 5'd5; hz.id_rs2_used = 1'b1;
    step(5'b00111, 2'b01, 1'b0, 1'b0);
    check_eq("state_lu_bubble", 32'(dut.state_q), 32'(LU_BUBBLE));
    idle_inputs();
    step(5'b11111, 2'b00, 1'b0, 1'b0);
    check_eq("state_back_run", 32'(dut.state_q), 32'(RUN));

    // Load-use via rs1; then matching but unused rs2; then non-writing load
    load_in_ex(5'd9);
    hz.id_rs1 = 5'd9; hz.id_rs1_used = 1'b1;
    step(5'b00111, 2'b01, 1'b0, 1'b0);
    idle_inputs();
    load_in_ex(5'd9);
    hz.id_rs2 = 5'd9; hz.id_rs2_used = 1'b0;
    hz.id_rs1 = 5'd4; hz.id_rs1_used = 1'b1;
    step(5'b11111, 2'b00, 1'b0, 1'b0);
    hz.id_rs2_used = 1'b1;
    hz.ex_reg_we   = 1'b0;
    step(5'b11111, 2'b00, 1'b0, 1'b0);

    // Load to x0 never stalls
    idle_inputs();
    load_in_ex(5'd0);
    hz.id_rs1 = 5'd0; hz.id_rs1_used = 1'b1;
    step(5'b11111, 2'b00, 1'b0, 1'b0);
    idle_inputs();
    step(5'b11111, 2'b00, 1'b0, 1'b0);

    // Redirect overrides load-use; branch-taken redirect
    do_reset();
    load_in_ex(5'd7);
    hz.id_rs1 = 5'd7; hz.id_rs1_used = 1'b1;
    hz.ex_jump_t = JAL_R;
    step(5'b11111, 2'b11, 1'b1, 1'b0);
    check_eq("state_redir_run", 32'(dut.state_q), 32'(RUN));
    idle_inputs();
    hz.ex_branch_taken = 1'b1;
    step(5'b11111, 2'b11, 1'b1, 1'b0);
    idle_inputs();
    step(5'b11111, 2'b00, 1'b0, 1'b0);

    // Freeze 3 cycles with JAL, redirect replayed from the pending flag
    do_reset();
    hz.mem_req = 1'b1; hz.ex_jump_t = JAL;
    for (int i = 0; i < 3; i++) step(5'b00000, 2'b00, 1'b0, 1'b0);
    hz.mem_ready = 1'b1; hz.ex_jump_t = NO_JUMP;
    step(5'b11111, 2'b11, 1'b1, 1'b0);
    idle_inputs();
    step(5'b11111, 2'b00, 1'b0, 1'b0);

    // Ready in the same cycle as the request: no freeze
    hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
    step(5'b11111, 2'b00, 1'b0, 1'b0);

    // Timeout: 6 wait cycles, flag visible from the 6th, sticky afterwards
    do_reset();
    hz.mem_req = 1'b1;
    for (int k = 1; k <= 6; k++) step(5'b00000, 2'b00, 1'b0, (k >= 6));
    hz.mem_ready = 1'b1;
    step(5'b11111, 2'b00, 1'b0, 1'b1);
    idle_inputs();
    step(5'b11111, 2'b00, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle clears everything
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_timeout", 32'(hz.mem_timeout), 32'h0);
    check_eq("arst_stall_cnt", 32'(stall_cnt), 32'h0);
    check_eq("arst_flush_cnt", 32'(flush_cnt), 32'h0);
    check_eq("arst_state", 32'(dut.state_q), 32'(RUN));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    exp_stall = 0;
    exp_flush = 0;

    // Reset mid-freeze drops the pending redirect
    hz.mem_req = 1'b1; hz.ex_jump_t = JAL;
    step(5'b00000, 2'b00, 1'b0, 1'b0);
    step(5'b00000, 2'b00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("frz_rst_state", 32'(dut.state_q), 32'(RUN));
    check_eq("frz_rst_pend", 32'(dut.redir_pend_q), 32'h0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    step(5'b11111, 2'b00, 1'b0, 1'b0);

    // Counter saturation: 10 frozen cycles on a 3-bit counter
    hz.mem_req = 1'b1;
    for (int k = 1; k <= 10; k++) step(5'b00000, 2'b00, 1'b0, (k >= 6));
    idle_inputs();
    step(5'b11111, 2'b00, 1'b0, 1'b1);
    check_eq("sat_stall_cnt", 32'(stall_cnt), 32'h7);
    check_eq("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
